// File: rtl/config_write_scheduler.sv
// Queues host config writes and commits them to the shadow register file in
// bursts aligned to the core's sample boundary, followed by a single apply pulse.
module config_write_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_WriteValid,
    output logic                          o_WriteReady,
    input  logic [9:0]                    i_WriteAddr,
    input  logic [15:0]                   i_WriteData,
    input  logic                          i_SampleReady,
    output logic                          o_CommitValid,
    output logic [9:0]                    o_CommitAddr,
    output logic [15:0]                   o_CommitData,
    output logic                          o_Apply,
    output logic [$clog2(FIFO_DEPTH):0]   o_Pending,
    output logic                          o_AddrError,
    output logic                          o_Overrun,
    input  logic                          i_ClearFlags
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(MAX_BURST);

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } cfg_wr_t;

    typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;

    cfg_wr_t        mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  rem;
    state_t         state;

    logic           accept, bad_op, push, start, pop;
    logic [CW-1:0]  snap;

    assign o_WriteReady = (o_Pending != DEPTH_C);
    assign accept = i_WriteValid && o_WriteReady;
    assign bad_op = (i_WriteAddr[5:3] > 3'd5);
    assign push   = accept && !bad_op;

    // The first entry is popped on the boundary edge itself so the commit
    // strobe is visible in the very next cycle; rem counts the rest.
    assign snap  = (o_Pending > BURST_C) ? BURST_C : o_Pending;
    assign start = (state == IDLE) && i_SampleReady && (o_Pending != '0);
    assign pop   = start || ((state == DRAIN) && (rem != '0));

    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= cfg_wr_t'{addr: i_WriteAddr, data: i_WriteData};
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_Pending     <= '0;
            rem           <= '0;
            state         <= IDLE;
            o_CommitValid <= 1'b0;
            o_CommitAddr  <= '0;
            o_CommitData  <= '0;
            o_Apply       <= 1'b0;
            o_AddrError   <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                o_CommitAddr <= mem[rd_ptr].addr;
                o_CommitData <= mem[rd_ptr].data;
            end
            o_Pending     <= o_Pending + CW'(push) - CW'(pop);
            o_CommitValid <= pop;
            o_Apply       <= 1'b0;

            case (state)
                IDLE: if (start) begin
                    rem   <= snap - 1'b1;
                    state <= DRAIN;
                end
                DRAIN: if (rem != '0) begin
                    rem <= rem - 1'b1;
                end else begin
                    o_Apply <= 1'b1;
                    state   <= APPLY;
                end
                APPLY: state <= IDLE;
                default: state <= IDLE;
            endcase

            // A same-edge set beats the clear
            o_AddrError <= (o_AddrError && !i_ClearFlags) || (accept && bad_op);
            o_Overrun   <= (o_Overrun && !i_ClearFlags) || (i_SampleReady && (state != IDLE));
        end
    end
endmodule

// File: tb/tb_config_write_scheduler.sv
// Directed and random stimulus for config_write_scheduler, checked every cycle
// against a queue-based model of the boundary/burst timing rules.
module tb_config_write_scheduler;
    localparam int DEPTH = 8;
    localparam int MAXB  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wv, sr, clr;
    logic [9:0]  wa;
    logic [15:0] wd;
    logic        ready, cv, apply, aerr, ovr;
    logic [9:0]  caddr;
    logic [15:0] cdata;
    logic [3:0]  pending;

    config_write_scheduler #(.FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
        .i_WriteValid(wv), .o_WriteReady(ready),
        .i_WriteAddr(wa), .i_WriteData(wd),
        .i_SampleReady(sr),
        .o_CommitValid(cv), .o_CommitAddr(caddr), .o_CommitData(cdata),
        .o_Apply(apply), .o_Pending(pending),
        .o_AddrError(aerr), .o_Overrun(ovr), .i_ClearFlags(clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: queued writes plus the edges at which the current batch ends
    logic [25:0] mq[$];
    int          edge_cnt = 0;
    int          idle_at, apply_edge, pops_left;
    logic        e_cv, e_apply, e_aerr, e_ovr;
    logic [9:0]  e_addr;
    logic [15:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        idle_at    = edge_cnt;
        apply_edge = -1;
        pops_left  = 0;
        e_cv = 0; e_apply = 0; e_aerr = 0; e_ovr = 0;
        e_addr = '0; e_data = '0;
    endtask

    task automatic check_all();
        chk("commit_valid", 32'(cv), 32'(e_cv));
        chk("commit_addr", 32'(caddr), 32'(e_addr));
        chk("commit_data", 32'(cdata), 32'(e_data));
        chk("apply", 32'(apply), 32'(e_apply));
        chk("pending", 32'(pending), 32'(mq.size()));
        chk("write_ready", 32'(ready), 32'(mq.size() < DEPTH));
        chk("addr_error", 32'(aerr), 32'(e_aerr));
        chk("overrun", 32'(ovr), 32'(e_ovr));
    endtask

    task automatic model_edge();
        int  sz, n;
        logic idle, acc, set_err, set_ovr;
        logic [25:0] ent;
        if (!rst_n) begin
            edge_cnt++;
            model_reset();
            return;
        end
        sz      = mq.size();
        idle    = (edge_cnt >= idle_at);
        acc     = wv && (sz < DEPTH);
        set_ovr = sr && !idle;
        set_err = 1'b0;
        if (sr && idle) begin
            n = (sz < MAXB) ? sz : MAXB;
            if (n > 0) begin
                pops_left  = n;
                apply_edge = edge_cnt + n;
                idle_at    = edge_cnt + n + 2;
            end
        end
        if (pops_left > 0) begin
            ent = mq.pop_front();
            e_cv = 1'b1;
            e_addr = ent[25:16];
            e_data = ent[15:0];
            pops_left--;
        end else begin
            e_cv = 1'b0;
        end
        e_apply = (edge_cnt == apply_edge);
        if (acc) begin
            if (wa[5:3] <= 3'd5) mq.push_back({wa, wd});
            else set_err = 1'b1;
        end
        e_aerr = (e_aerr && !clr) || set_err;
        e_ovr  = (e_ovr && !clr) || set_ovr;
        edge_cnt++;
    endtask

    task automatic step(input logic v, input logic [9:0] a, input logic [15:0] d,
                        input logic s, input logic c);
        wv = v; wa = a; wd = d; sr = s; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d);
        step(1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic boundary();
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        wv = 0; wa = '0; wd = '0; sr = 0; clr = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        idle(2);
        #3 rst_n = 1'b1;

        // Three writes, one boundary: commits in order, then apply
        wr(10'h041, 16'h1234);
        wr(10'h08A, 16'h00FF);
        wr(10'h3E8, 16'h7FFF);
        boundary();
        idle(6);

        // Fill, stall the ninth write across a limited-burst boundary
        for (int i = 0; i < DEPTH; i++) wr(10'((i << 6) | (i % 6) << 3), 16'(16'hA000 + i));
        step(1'b1, 10'h111, 16'hBEEF, 1'b0, 1'b0);
        chk("stall_ready", 32'(ready), 32'd0);
        step(1'b1, 10'h111, 16'hBEEF, 1'b1, 1'b0);
        step(1'b1, 10'h111, 16'hBEEF, 1'b0, 1'b0);
        idle(6);
        boundary(); idle(6);
        boundary(); idle(3);

        // Operator 7 is dropped and flagged until cleared
        wr(10'h038, 16'h5555);
        boundary(); idle(4);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(1);

        // Boundary repeated mid-drain
        for (int i = 0; i < 4; i++) wr(10'(10'h200 + i), 16'(16'h1100 + i));
        boundary(); idle(1); boundary(); idle(6);
        boundary(); idle(2);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Reset in the middle of a drain
        for (int i = 0; i < 5; i++) wr(10'(10'h0C0 + i), 16'(16'h2200 + i));
        boundary(); idle(1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        idle(2);
        #3 rst_n = 1'b1;
        boundary(); idle(4);

        // Write on the boundary edge is not part of the batch
        wr(10'h010, 16'h0001);
        wr(10'h010, 16'h0002);
        step(1'b1, 10'h010, 16'h0003, 1'b1, 1'b0);
        idle(5);
        boundary(); idle(4);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 2) != 0, 10'($urandom), 16'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
